// File: rtl/sar_search_pkg.sv
// sar_search_pkg: shared state encoding and default operand width
package sar_search_pkg;
  localparam int WIDTH_DEF = 4;
  typedef enum logic {IDLE, SEARCH} state_t;
endpackage

// File: rtl/sar_search.sv
// sar_search: MSB-first successive-approximation search against an external comparator
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         cmp_gt,
  input  logic                         cmp_lt,
  input  logic                         cmp_eq,
  output logic [WIDTH-1:0]             trial,
  output logic                         busy,
  output logic                         done,
  output logic [WIDTH-1:0]             result,
  output logic                         err,
  output logic [$clog2(WIDTH+1)-1:0]   steps
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
  localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);
  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_trial, w_trial;
  logic [IW-1:0]    r_idx, w_idx;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [WIDTH-1:0] r_result, w_result;
  logic             r_err, w_err;
  logic [CW-1:0]    r_steps, w_steps;
  logic             r_done, w_done;
  logic             w_onehot;
  assign w_onehot = $onehot({cmp_gt, cmp_lt, cmp_eq});
  assign trial  = r_trial;
  assign busy   = (r_state == SEARCH);
  assign done   = r_done;
  assign result = r_result;
  assign err    = r_err;
  assign steps  = r_steps;
  // state and datapath registers; reset discards any search in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_trial  <= '0;
      r_idx    <= TOP;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_steps  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_trial  <= w_trial;
      r_idx    <= w_idx;
      r_cnt    <= w_cnt;
      r_result <= w_result;
      r_err    <= w_err;
      r_steps  <= w_steps;
      r_done   <= w_done;
    end
  end
  // next state: one compare per cycle, finishing on bad flags, equality or the last bit
  always_comb begin
    w_state  = r_state;
    w_trial  = r_trial;
    w_idx    = r_idx;
    w_cnt    = r_cnt;
    w_result = r_result;
    w_err    = r_err;
    w_steps  = r_steps;
    w_done   = 1'b0;
    if (r_state == IDLE) begin
      if (start) begin
        w_state = SEARCH;
        w_trial = MSB;
        w_idx   = TOP;
        w_cnt   = CW'(1);
      end
    end else if (!w_onehot || cmp_eq || r_idx == '0) begin
      w_state  = IDLE;
      w_trial  = '0;
      w_idx    = TOP;
      w_done   = 1'b1;
      w_steps  = r_cnt;
      w_err    = !w_onehot;
      w_result = r_trial;
      if (w_onehot && cmp_lt) w_result[0] = 1'b0;
    end else begin
      if (cmp_lt) w_trial[r_idx] = 1'b0;
      w_trial[r_idx - 1'b1] = 1'b1;
      w_idx = r_idx - 1'b1;
      w_cnt = r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: directed scoreboard bench with a behavioural magnitude comparator
module tb_sar_search;
  import sar_search_pkg::*;
  localparam int W  = WIDTH_DEF;
  localparam int SW = $clog2(W + 1);
  typedef struct {
    logic [W-1:0]  res;
    logic          err;
    logic [SW-1:0] st;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] target = '0;
  logic f_en = 1'b0, f_gt = 1'b0, f_lt = 1'b0, f_eq = 1'b0;
  logic cmp_gt, cmp_lt, cmp_eq;
  logic [W-1:0] trial, result;
  logic busy, done, err;
  logic [SW-1:0] steps;
  exp_t q[$];
  int total = 0, bad = 0, n_done = 0;
  assign cmp_gt = f_en ? f_gt : (target > trial);
  assign cmp_lt = f_en ? f_lt : (target < trial);
  assign cmp_eq = f_en ? f_eq : (target == trial);
  sar_search #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .trial(trial), .busy(busy), .done(done),
    .result(result), .err(err), .steps(steps)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // compares needed: equality hits when the trial bit reaches the target's lowest set bit
  function automatic int exp_steps(input int t);
    if (t == 0) return W;
    for (int b = 0; b < W; b++) if (t[b]) return W - b;
    return W;
  endfunction
  task automatic push(input int r, input logic e, input int s);
    exp_t x;
    x.res = W'(r);
    x.err = e;
    x.st  = SW'(s);
    q.push_back(x);
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 3 * W);
    chk(tag, done, 1);
  endtask
  task automatic run_search(input int t);
    target = W'(t);
    push(t, 1'b0, exp_steps(t));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done($sformatf("done_t%0d", t));
  endtask
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      n_done++;
      chk("done_busy", busy, 0);
      if (q.size() == 0) chk("spurious_done", done, 0);
      else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("err", err, e.err);
        chk("steps", steps, e.st);
      end
    end
  end
  initial begin
    int d0;
    repeat (2) @(negedge clk);
    chk("rst_trial", trial, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    chk("rst_steps", steps, 0);
    rst = 1'b0;
    @(negedge clk);
    target = 5;
    push(5, 1'b0, 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_trial0", trial, 8);
    chk("t5_busy", busy, 1);
    @(negedge clk);
    chk("t5_trial1", trial, 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_trial2", trial, 6);
    @(negedge clk);
    chk("t5_trial3", trial, 5);
    @(negedge clk);
    chk("t5_done", done, 1);
    @(negedge clk);
    chk("t5_done_once", done, 0);
    chk("t5_held", result, 5);
    chk("t5_idle_trial", trial, 0);
    chk("t5_no_requeue", busy, 0);
    target = 8;
    push(8, 1'b0, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t8_busy", busy, 1);
    @(negedge clk);
    chk("t8_done", done, 1);
    run_search(0);
    run_search(15);
    target = 5;
    push(4, 1'b1, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    f_en = 1'b1;
    f_gt = 1'b1;
    f_lt = 1'b1;
    f_eq = 1'b0;
    @(negedge clk);
    f_en = 1'b0;
    chk("bad_flags_done", done, 1);
    chk("bad_flags_err", err, 1);
    @(negedge clk);
    target = 5;
    push(5, 1'b0, 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_trial", trial, 6);
    rst = 1'b1;
    #1;
    chk("arst_trial", trial, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    chk("arst_err", err, 0);
    chk("arst_steps", steps, 0);
    void'(q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_done", done, 0);
    run_search(11);
    chk("t11_result", result, 11);
    @(negedge clk);
    d0 = n_done;
    target = 0;
    push(0, 1'b0, exp_steps(0));
    start = 1'b1;
    for (int t = 0; t < (1 << W); t++) begin
      wait_done($sformatf("b2b_t%0d", t));
      if (t < (1 << W) - 1) begin
        target = W'(t + 1);
        push(t + 1, 1'b0, exp_steps(t + 1));
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("b2b_pulses", n_done - d0, 1 << W);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
